router_fsm_np: RTL and testbench



---
 rtl/router_fsm_np.sv | 156 +++++++++++++++
 tb/tb_router_fsm_np.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm_np.sv
// Router control FSM for NUM_PORTS output FIFOs: latches the destination,
// drops illegal or starved packets, and drives the FIFO write/control strobes.
module router_fsm_np #(
   parameter int NUM_PORTS    = 3,
   parameter int ADDR_W       = 2,
   parameter int WAIT_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pkt_valid,
   input  logic                 parity_done,
   input  logic                 low_pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic [NUM_PORTS-1:0] soft_reset,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic                 fifo_full,
   output logic                 busy,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 full_state,
   output logic                 write_en_reg,
   output logic                 rst_int_reg,
   output logic                 drop_state,
   output logic                 timeout_err,
   output logic [ADDR_W-1:0]    dest_addr
);

   localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      WAIT_TILL_EMPTY    = 4'd3,
      FIFO_FULL_STATE    = 4'd4,
      LOAD_AFTER_FULL    = 4'd5,
      LOAD_PARITY        = 4'd6,
      CHECK_PARITY_ERROR = 4'd7,
      DROP_PACKET        = 4'd8
   } state_t;

   state_t                  state, next_state;
   logic [2**ADDR_W-1:0]    empty_ext, soft_ext;
   logic [CNT_W-1:0]        wait_cnt;
   logic                    soft_hit, timeout_hit, addr_illegal;

   // Widen per-port vectors to the full address space so any address indexes safely.
   always_comb begin
      empty_ext = '0;
      soft_ext  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         empty_ext[i] = fifo_empty[i];
         soft_ext[i]  = soft_reset[i];
      end
   end

   assign addr_illegal = {1'b0, data_in} >= (ADDR_W+1)'(NUM_PORTS);
   assign soft_hit = (state != DECODE_ADDRESS) && (state != DROP_PACKET) && soft_ext[dest_addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= DECODE_ADDRESS;
         dest_addr   <= '0;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= soft_hit ? DECODE_ADDRESS : next_state;
         timeout_err <= timeout_hit && !soft_hit;
         if (state == DECODE_ADDRESS && pkt_valid)
            dest_addr <= data_in;
         // Counter restarts on every entry to WAIT and saturates instead of wrapping.
         if (state == WAIT_TILL_EMPTY && next_state == WAIT_TILL_EMPTY && !soft_hit) begin
            if (wait_cnt != CNT_MAX)
               wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   always_comb begin
      next_state   = DECODE_ADDRESS;
      timeout_hit  = 1'b0;
      busy         = 1'b1;
      detect_add   = 1'b0;
      lfd_state    = 1'b0;
      ld_state     = 1'b0;
      laf_state    = 1'b0;
      full_state   = 1'b0;
      write_en_reg = 1'b0;
      rst_int_reg  = 1'b0;
      drop_state   = 1'b0;
      case (state)
         DECODE_ADDRESS: begin
            detect_add = 1'b1;
            busy       = 1'b0;
            if (pkt_valid && addr_illegal)       next_state = DROP_PACKET;
            else if (pkt_valid && empty_ext[data_in]) next_state = LOAD_FIRST_DATA;
            else if (pkt_valid)                  next_state = WAIT_TILL_EMPTY;
            else                                 next_state = DECODE_ADDRESS;
         end
         LOAD_FIRST_DATA: begin
            lfd_state  = 1'b1;
            next_state = LOAD_DATA;
         end
         LOAD_DATA: begin
            ld_state     = 1'b1;
            write_en_reg = 1'b1;
            busy         = 1'b0;
            if (fifo_full)       next_state = FIFO_FULL_STATE;
            else if (!pkt_valid) next_state = LOAD_PARITY;
            else                 next_state = LOAD_DATA;
         end
         WAIT_TILL_EMPTY: begin
            if (empty_ext[dest_addr]) begin
               next_state = LOAD_FIRST_DATA;
            end else if (WAIT_TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
               next_state  = DROP_PACKET;
               timeout_hit = 1'b1;
            end else begin
               next_state = WAIT_TILL_EMPTY;
            end
         end
         FIFO_FULL_STATE: begin
            full_state = 1'b1;
            next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            laf_state    = 1'b1;
            write_en_reg = 1'b1;
            if (parity_done)        next_state = DECODE_ADDRESS;
            else if (low_pkt_valid) next_state = LOAD_PARITY;
            else                    next_state = LOAD_DATA;
         end
         LOAD_PARITY: begin
            write_en_reg = 1'b1;
            next_state   = CHECK_PARITY_ERROR;
         end
         CHECK_PARITY_ERROR: begin
            rst_int_reg = 1'b1;
            next_state  = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         DROP_PACKET: begin
            drop_state = 1'b1;
            busy       = 1'b0;
            next_state = pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
         end
         default: next_state = DECODE_ADDRESS;
      endcase
   end

endmodule

// File: tb/tb_router_fsm_np.sv
// Directed bench for router_fsm_np; a second instance with WAIT_TIMEOUT=0
// shares the stimulus to show the indefinite wait.
module tb_router_fsm_np;

   logic       clk = 1'b0;
   logic       reset, pkt_valid, parity_done, low_pkt_valid, fifo_full;
   logic [1:0] data_in;
   logic [2:0] soft_reset, fifo_empty;

   logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_en_reg, rst_int_reg, drop_state, timeout_err;
   logic [1:0] dest_addr;
   logic       z_busy, z_detect_add, z_lfd, z_ld, z_laf, z_full;
   logic       z_we, z_rst_int, z_drop, z_terr;
   logic [1:0] z_dest;

   int n_checks = 0;
   int n_fail   = 0;

   // Observed vector: {detect,lfd,ld,laf,full,rst_int,drop,write_en,busy}
   localparam logic [8:0] S_DEC  = 9'b1_0000_00_0_0;
   localparam logic [8:0] S_LFD  = 9'b0_1000_00_0_1;
   localparam logic [8:0] S_LD   = 9'b0_0100_00_1_0;
   localparam logic [8:0] S_LAF  = 9'b0_0010_00_1_1;
   localparam logic [8:0] S_FULL = 9'b0_0001_00_0_1;
   localparam logic [8:0] S_LP   = 9'b0_0000_00_1_1;
   localparam logic [8:0] S_CPE  = 9'b0_0000_10_0_1;
   localparam logic [8:0] S_WAIT = 9'b0_0000_00_0_1;
   localparam logic [8:0] S_DROP = 9'b0_0000_01_0_0;

   logic [8:0] obs, zobs;
   assign obs  = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  rst_int_reg, drop_state, write_en_reg, busy};
   assign zobs = {z_detect_add, z_lfd, z_ld, z_laf, z_full, z_rst_int, z_drop, z_we, z_busy};

   router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .parity_done(parity_done),
      .low_pkt_valid(low_pkt_valid), .data_in(data_in), .soft_reset(soft_reset),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .busy(busy),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state), .write_en_reg(write_en_reg),
      .rst_int_reg(rst_int_reg), .drop_state(drop_state), .timeout_err(timeout_err),
      .dest_addr(dest_addr));

   router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(0)) dut0 (
      .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .parity_done(parity_done),
      .low_pkt_valid(low_pkt_valid), .data_in(data_in), .soft_reset(soft_reset),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .busy(z_busy),
      .detect_add(z_detect_add), .lfd_state(z_lfd), .ld_state(z_ld),
      .laf_state(z_laf), .full_state(z_full), .write_en_reg(z_we),
      .rst_int_reg(z_rst_int), .drop_state(z_drop), .timeout_err(z_terr),
      .dest_addr(z_dest));

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pkt_valid = 0; parity_done = 0; low_pkt_valid = 0; fifo_full = 0;
      data_in = 0; soft_reset = 0; fifo_empty = 3'b111;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      step(); step();
      reset = 0;
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", obs, S_DEC); end
      n_checks++;
      if (dest_addr !== 2'd0) begin n_fail++; $display("FAIL reset_dest got=%0d exp=0", dest_addr); end
      n_checks++;
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
   endtask

   task automatic test_normal();
      int we_cnt = 0;
      fifo_empty = 3'b111; data_in = 2'd1; pkt_valid = 1;
      step();
      n_checks++;
      if (obs !== S_LFD) begin n_fail++; $display("FAIL normal_lfd got=%b exp=%b", obs, S_LFD); end
      data_in = 2'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (obs !== S_LD) begin n_fail++; $display("FAIL normal_ld%0d got=%b exp=%b", i, obs, S_LD); end
         if (write_en_reg) we_cnt++;
         if (i == 3) pkt_valid = 0;
      end
      step();
      n_checks++;
      if (obs !== S_LP) begin n_fail++; $display("FAIL normal_lp got=%b exp=%b", obs, S_LP); end
      if (write_en_reg) we_cnt++;
      step();
      n_checks++;
      if (obs !== S_CPE) begin n_fail++; $display("FAIL normal_cpe got=%b exp=%b", obs, S_CPE); end
      if (write_en_reg) we_cnt++;
      step();
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL normal_dec got=%b exp=%b", obs, S_DEC); end
      n_checks++;
      if (we_cnt != 5) begin n_fail++; $display("FAIL normal_we_cycles got=%0d exp=5", we_cnt); end
      n_checks++;
      if (dest_addr !== 2'd1) begin n_fail++; $display("FAIL normal_dest got=%0d exp=1", dest_addr); end
   endtask

   task automatic test_illegal();
      data_in = 2'd3; pkt_valid = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (obs !== S_DROP) begin n_fail++; $display("FAIL illegal_drop%0d got=%b exp=%b", i, obs, S_DROP); end
      end
      n_checks++;
      if (dest_addr !== 2'd3) begin n_fail++; $display("FAIL illegal_dest got=%0d exp=3", dest_addr); end
      pkt_valid = 0; data_in = 2'd0;
      step();
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL illegal_dec got=%b exp=%b", obs, S_DEC); end
   endtask

   task automatic test_wait_empty();
      fifo_empty = 3'b011; data_in = 2'd2; pkt_valid = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (obs !== S_WAIT) begin n_fail++; $display("FAIL wait_state%0d got=%b exp=%b", i, obs, S_WAIT); end
      end
      fifo_empty = 3'b111;
      step();
      n_checks++;
      if (obs !== S_LFD) begin n_fail++; $display("FAIL wait_lfd got=%b exp=%b", obs, S_LFD); end
      n_checks++;
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL wait_terr got=%b exp=0", timeout_err); end
      n_checks++;
      if (dest_addr !== 2'd2) begin n_fail++; $display("FAIL wait_dest got=%0d exp=2", dest_addr); end
      pkt_valid = 0;
      step(); step(); step(); step();
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL wait_done got=%b exp=%b", obs, S_DEC); end
   endtask

   task automatic test_timeout();
      fifo_empty = 3'b110; data_in = 2'd0; pkt_valid = 1;
      for (int i = 0; i < 16; i++) begin
         step();
         n_checks++;
         if (obs !== S_WAIT || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_wait%0d got=%b/%b exp=%b/0", i, obs, timeout_err, S_WAIT);
         end
      end
      step();
      n_checks++;
      if (obs !== S_DROP || timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL timeout_drop got=%b/%b exp=%b/1", obs, timeout_err, S_DROP);
      end
      step();
      n_checks++;
      if (obs !== S_DROP || timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_pulse got=%b/%b exp=%b/0", obs, timeout_err, S_DROP);
      end
      n_checks++;
      if (zobs !== S_WAIT) begin n_fail++; $display("FAIL notimeout_early got=%b exp=%b", zobs, S_WAIT); end
      pkt_valid = 0;
      step();
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL timeout_dec got=%b exp=%b", obs, S_DEC); end
   endtask

   task automatic test_no_timeout();
      int bad = 0;
      test_reset();
      fifo_empty = 3'b110; data_in = 2'd0; pkt_valid = 1;
      step();
      pkt_valid = 0;
      for (int i = 0; i < 100; i++) begin
         if (zobs !== S_WAIT || z_terr !== 1'b0) bad++;
         step();
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL notimeout_wait bad_cycles=%0d exp=0", bad); end
      fifo_empty = 3'b111;
      step();
      n_checks++;
      if (zobs !== S_LFD) begin n_fail++; $display("FAIL notimeout_lfd got=%b exp=%b", zobs, S_LFD); end
   endtask

   task automatic test_soft_reset();
      test_reset();
      fifo_empty = 3'b111; data_in = 2'd1; pkt_valid = 1;
      step(); step();
      n_checks++;
      if (obs !== S_LD) begin n_fail++; $display("FAIL soft_setup got=%b exp=%b", obs, S_LD); end
      soft_reset = 3'b100;
      step();
      n_checks++;
      if (obs !== S_LD) begin n_fail++; $display("FAIL soft_other_port got=%b exp=%b", obs, S_LD); end
      soft_reset = 3'b010;
      step();
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL soft_own_port got=%b exp=%b", obs, S_DEC); end
      soft_reset = 3'b000; pkt_valid = 0;
      step();
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL soft_idle got=%b exp=%b", obs, S_DEC); end
   endtask

   task automatic test_full_reset();
      test_reset();
      fifo_empty = 3'b111; data_in = 2'd1; pkt_valid = 1;
      step(); step();
      fifo_full = 1;
      step();
      n_checks++;
      if (obs !== S_FULL) begin n_fail++; $display("FAIL full_enter got=%b exp=%b", obs, S_FULL); end
      step();
      n_checks++;
      if (obs !== S_FULL) begin n_fail++; $display("FAIL full_hold got=%b exp=%b", obs, S_FULL); end
      fifo_full = 0; low_pkt_valid = 1;
      step();
      n_checks++;
      if (obs !== S_LAF) begin n_fail++; $display("FAIL full_laf got=%b exp=%b", obs, S_LAF); end
      step();
      n_checks++;
      if (obs !== S_LP) begin n_fail++; $display("FAIL full_lp got=%b exp=%b", obs, S_LP); end
      low_pkt_valid = 0; pkt_valid = 0;
      fifo_full = 1;
      step();
      n_checks++;
      if (obs !== S_CPE) begin n_fail++; $display("FAIL full_cpe got=%b exp=%b", obs, S_CPE); end
      step();
      n_checks++;
      if (obs !== S_FULL) begin n_fail++; $display("FAIL cpe_to_full got=%b exp=%b", obs, S_FULL); end
      fifo_full = 0; parity_done = 1;
      step(); step();
      n_checks++;
      if (obs !== S_DEC) begin n_fail++; $display("FAIL laf_parity_done got=%b exp=%b", obs, S_DEC); end
      parity_done = 0;
      data_in = 2'd2; pkt_valid = 1;
      step(); step();
      fifo_full = 1;
      step();
      n_checks++;
      if (obs !== S_FULL || dest_addr !== 2'd2) begin
         n_fail++; $display("FAIL full_again got=%b/%0d exp=%b/2", obs, dest_addr, S_FULL);
      end
      reset = 1;
      step();
      reset = 0; fifo_full = 0; pkt_valid = 0;
      n_checks++;
      if (obs !== S_DEC || dest_addr !== 2'd0) begin
         n_fail++; $display("FAIL full_reset got=%b/%0d exp=%b/0", obs, dest_addr, S_DEC);
      end
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_normal();
      test_illegal();
      test_wait_empty();
      test_timeout();
      test_no_timeout();
      test_soft_reset();
      test_full_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
